instr_mem_loadable: RTL and testbench
=====================================

Name: instr_mem_loadable

Overview:
- Parametrised, synchronous successor of the combinational instruction memory in the IF stage.
- Word-addressed RAM that software or the testbench fills at run time through a streaming load port, replacing the hard-coded program.
- Serves IF-stage fetches with one-cycle registered latency.
- Supports pipeline freeze (hazard stall) and returns a NOP for fetches outside the loaded region.

Parameters:
- ADDR_WIDTH, 32, width of the byte address from the PC; bits [1:0] are ignored.
- DATA_WIDTH, 32, instruction word width.
- DEPTH, 256, number of instruction words; must be a power of two.
- NOP_WORD, 32'h0000_0000, word returned for out-of-range or unserved fetches.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_start  in  1  one-cycle pulse: begin a new program load and reset the load pointer.
- load_valid  in  1  load_data is valid this cycle.
- load_data  in  DATA_WIDTH  instruction word to store at the load pointer.
- load_done  in  1  one-cycle pulse: program complete; enter RUN.
- load_overflow  out  1  sticky; set when a write is attempted with the pointer at DEPTH.
- ready  out  1  high in RUN only.
- fetch_en  in  1  fetch request from IF stage.
- freeze  in  1  hazard stall; hold the fetch outputs.
- pc  in  ADDR_WIDTH  byte address of the fetch.
- instr  out  DATA_WIDTH  fetched instruction (registered).
- instr_valid  out  1  instr is valid this cycle.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=EMPTY, load pointer=0, word count=0.
  - instr=NOP_WORD, instr_valid=0, ready=0, load_overflow=0.
  - Memory array is not cleared.
- State machine, three states: EMPTY, LOADING, RUN.
  - load_start in any state: go to LOADING, pointer=0, count=0, load_overflow=0.
  - LOADING, load_done: go to RUN, count latched.
  - load_done outside LOADING is ignored.
- Load writes (LOADING, load_valid=1):
  - If pointer < DEPTH: mem[pointer] <= load_data, then pointer++.
  - If pointer == DEPTH: write dropped, load_overflow <= 1.
  - load_valid outside LOADING is ignored.
- Simultaneous events:
  - load_start with load_done or load_valid: load_start wins; data is not written; state stays LOADING.
  - load_valid with load_done: the write happens, count = pointer+1 (saturates at DEPTH), then RUN.
- Fetch, word index = pc[log2(DEPTH)+1:2]; upper pc bits must be zero, otherwise out of range.
  - RUN, fetch_en=1, freeze=0: at the next edge, instr <= mem[index] if in range and index < count, else NOP_WORD; instr_valid <= 1. Latency is exactly 1 cycle.
  - RUN, fetch_en=0, freeze=0: instr_valid <= 0; instr holds its value.
  - freeze=1 (any state except a reset or load_start cycle): instr and instr_valid hold; pc is ignored.
  - EMPTY or LOADING: instr <= NOP_WORD, instr_valid <= 0, ready=0.
- ready is a registered function of state; it asserts the cycle after the RUN transition.
- Reset mid-load: EMPTY immediately; a partial program is never served.
- load_start while in RUN: ready drops next cycle; an in-flight instr_valid clears next cycle.

Decomposition:
- Shared package / configs include:
  - state encoding (EMPTY=2'd0, LOADING=2'd1, RUN=2'd2).
  - NOP word constant.
  - default ADDR_WIDTH / DATA_WIDTH, alongside ADDRESS_LEN.
- One natural sub-module: instr_mem_ram, a single-port synchronous RAM (DEPTH x DATA_WIDTH) with write-enable and a registered read.
- The control FSM, pointer, count and out-of-range logic live in the top.

Test Plan:
- Reset then load 4 words (E3A00015, E3A01A01, E3A0DC02, E58F0000) and pulse load_done -> ready=1 two cycles later; fetches of pc=0,4,8,C return those words one cycle after each request, instr_valid=1.
- pc=0x10 after the 4-word load -> instr=00000000, instr_valid=1; pc=0x0001_0000 (upper bits set) -> 00000000.
- Fetch pc=4 with freeze=1 held for 3 cycles after a valid fetch of pc=0 -> instr holds E3A00015, valid held; after release, pc=4 yields E3A01A01.
- DEPTH=4: load 5 words -> load_overflow=1; count=4; fetch pc=0xC returns the 4th word, not the 5th.
- Assert rst mid-load after 2 words, then fetch with fetch_en=1 -> ready=0, instr_valid=0, instr=00000000 until a new load completes.
- Same-cycle load_valid+load_done on the 3rd word -> count=3, pc=8 returns the 3rd word; load_start+load_valid same cycle -> no write, pointer=0.

Source files
------------

// File: rtl/instr_mem_loadable_pkg.sv
// Shared constants and types for the loadable instruction memory.
package instr_mem_loadable_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 32;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned ADDRESS_LEN    = DEF_ADDR_WIDTH;
    localparam int unsigned DEF_DEPTH      = 256;

    // Word returned for out-of-range or unserved fetches.
    localparam logic [DEF_DATA_WIDTH-1:0] DEF_NOP_WORD = 32'h0000_0000;

    // Control states.
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_LOADING = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

endpackage

// File: rtl/instr_mem_loadable_if.sv
// Load-port and fetch-port bundle between the IF stage / loader and the memory.
interface instr_mem_loadable_if
    import instr_mem_loadable_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic                  load_start;
    logic                  load_valid;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_done;
    logic                  load_overflow;
    logic                  ready;
    logic                  fetch_en;
    logic                  freeze;
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
    logic                  instr_valid;

    // Loader / IF-stage side.
    modport master (
        output load_start, load_valid, load_data, load_done,
        output fetch_en, freeze, pc,
        input  load_overflow, ready, instr, instr_valid
    );

    // Memory side.
    modport slave (
        input  load_start, load_valid, load_data, load_done,
        input  fetch_en, freeze, pc,
        output load_overflow, ready, instr, instr_valid
    );

endinterface

// File: rtl/instr_mem_loadable_ram.sv
// Single-port synchronous RAM with write enable and registered, enable-gated read.
module instr_mem_ram #(
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IDX_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [IDX_W-1:0]      i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Array write; contents survive reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Read register only updates on a read so the last fetched word is held.
    always_ff @(posedge clk) begin
        if (i_re && !i_we) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_mem_loadable.sv
// Run-time loadable instruction memory: streaming load port, 1-cycle registered fetch.
module instr_mem_loadable
    import instr_mem_loadable_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned           DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned           DEPTH      = DEF_DEPTH,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = DATA_WIDTH'(DEF_NOP_WORD)
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_mem_loadable_if.slave  bus
);

    localparam int unsigned        IDX_W   = $clog2(DEPTH);
    localparam int unsigned        PTR_W   = IDX_W + 1;
    localparam logic [PTR_W-1:0]   DEPTH_P = PTR_W'(DEPTH);

    state_t                r_state;
    state_t                w_next_state;
    logic [PTR_W-1:0]      r_ptr;
    logic [PTR_W-1:0]      r_count;
    logic [PTR_W-1:0]      w_count_done;
    logic                  r_overflow;
    logic                  r_ready;
    logic                  r_valid;
    logic                  r_use_ram;
    logic                  w_loading;
    logic                  w_has_room;
    logic                  w_we;
    logic                  w_re;
    logic                  w_fetch;
    logic                  w_in_range;
    logic                  w_hit;
    logic [IDX_W-1:0]      w_idx;
    logic [IDX_W-1:0]      w_ram_addr;
    logic [DATA_WIDTH-1:0] w_ram_rdata;

    // A load cycle only counts when it is not overridden by a same-cycle load_start.
    assign w_loading  = (r_state == ST_LOADING) && !bus.load_start;
    assign w_has_room = (r_ptr < DEPTH_P);
    assign w_we       = w_loading && bus.load_valid && w_has_room;

    // Word count latched at load_done, including a same-cycle final word.
    assign w_count_done = !bus.load_valid ? r_ptr :
                          (w_has_room ? PTR_W'(r_ptr + 1'b1) : DEPTH_P);

    // Fetch decode: upper pc bits must be zero and the word must be loaded.
    assign w_idx      = bus.pc[IDX_W+1:2];
    assign w_in_range = ((bus.pc >> (IDX_W + 2)) == '0);
    assign w_hit      = w_in_range && ({1'b0, w_idx} < r_count);
    assign w_fetch    = (r_state == ST_RUN) && bus.fetch_en && !bus.freeze && !bus.load_start;
    assign w_re       = w_fetch && w_hit;

    // Loading and fetching never overlap, so one address port serves both.
    assign w_ram_addr = (r_state == ST_LOADING) ? r_ptr[IDX_W-1:0] : w_idx;

    instr_mem_ram #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_addr  (w_ram_addr),
        .i_wdata (bus.load_data),
        .o_rdata (w_ram_rdata)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: load_start restarts from anywhere; load_done only matters while loading.
    always_comb begin
        w_next_state = r_state;
        if (bus.load_start) begin
            w_next_state = ST_LOADING;
        end else begin
            case (r_state)
                ST_LOADING: if (bus.load_done) w_next_state = ST_RUN;
                ST_EMPTY,
                ST_RUN:     w_next_state = r_state;
                default:    w_next_state = ST_EMPTY;
            endcase
        end
    end

    // Load pointer, word count and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (bus.load_start) begin
            r_ptr      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (w_loading) begin
            if (bus.load_valid) begin
                if (w_has_room) begin
                    r_ptr <= PTR_W'(r_ptr + 1'b1);
                end else begin
                    r_overflow <= 1'b1;
                end
            end
            if (bus.load_done) begin
                r_count <= w_count_done;
            end
        end
    end

    // Ready follows RUN one cycle late and drops right after a restart request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= (r_state == ST_RUN) && !bus.load_start;
        end
    end

    // Fetch output control; r_use_ram selects the RAM word over the NOP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_use_ram <= 1'b0;
        end else if (bus.load_start) begin
            r_valid   <= 1'b0;
            r_use_ram <= 1'b0;
        end else if (bus.freeze) begin
            r_valid   <= r_valid;
            r_use_ram <= r_use_ram;
        end else if (r_state == ST_RUN) begin
            if (bus.fetch_en) begin
                r_valid   <= 1'b1;
                r_use_ram <= w_hit;
            end else begin
                r_valid   <= 1'b0;
            end
        end else begin
            r_valid   <= 1'b0;
            r_use_ram <= 1'b0;
        end
    end

    // Both mux inputs are flops, so instr stays a registered output.
    assign bus.instr         = r_use_ram ? w_ram_rdata : NOP_WORD;
    assign bus.instr_valid   = r_valid;
    assign bus.ready         = r_ready;
    assign bus.load_overflow = r_overflow;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Self-checking bench for instr_mem_loadable: directed scenarios plus randomized fetch traffic.
module tb_instr_mem_loadable;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    instr_mem_loadable_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_a ();
    instr_mem_loadable_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_b ();

    instr_mem_loadable #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .NOP_WORD(32'h0)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    instr_mem_loadable #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4), .NOP_WORD(32'h0)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the program currently being served by each memory.
    logic [31:0] prog_a[$];
    logic [31:0] prog_b[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %-16s got %08h exp %08h", tag, got, exp);
        end
    endtask

    // A fetch is served iff its word address lies inside the loaded program.
    function automatic logic [31:0] ref_fetch(input bit b, input logic [31:0] pc);
        logic [31:0] waddr;
        int unsigned n;
        waddr = pc >> 2;
        n = b ? prog_b.size() : prog_a.size();
        if (waddr < n) return b ? prog_b[waddr] : prog_a[waddr];
        return 32'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_load(input bit b, input logic s, input logic v,
                            input logic [31:0] d, input logic dn);
        if (b) begin
            bus_b.load_start = s; bus_b.load_valid = v; bus_b.load_data = d; bus_b.load_done = dn;
        end else begin
            bus_a.load_start = s; bus_a.load_valid = v; bus_a.load_data = d; bus_a.load_done = dn;
        end
    endtask

    task automatic drv_fetch(input bit b, input logic fe, input logic fz, input logic [31:0] pc);
        if (b) begin
            bus_b.fetch_en = fe; bus_b.freeze = fz; bus_b.pc = pc;
        end else begin
            bus_a.fetch_en = fe; bus_a.freeze = fz; bus_a.pc = pc;
        end
    endtask

    task automatic check_outs(input bit b, input string tag, input logic [31:0] ei,
                              input logic ev, input logic er);
        if (b) begin
            check({tag, ".instr"}, bus_b.instr, ei);
            check({tag, ".valid"}, 32'(bus_b.instr_valid), 32'(ev));
            check({tag, ".ready"}, 32'(bus_b.ready), 32'(er));
        end else begin
            check({tag, ".instr"}, bus_a.instr, ei);
            check({tag, ".valid"}, 32'(bus_a.instr_valid), 32'(ev));
            check({tag, ".ready"}, 32'(bus_a.ready), 32'(er));
        end
    endtask

    // Pulse load_start, stream the words, finish with load_done; returns right after the done edge.
    task automatic load_prog(input bit b, input logic [31:0] w[$], input bit merge_done);
        drv_load(b, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        for (int i = 0; i < w.size(); i++) begin
            drv_load(b, 1'b0, 1'b1, w[i], merge_done && (i == w.size() - 1));
            tick();
        end
        if (!merge_done || w.size() == 0) begin
            drv_load(b, 1'b0, 1'b0, 32'h0, 1'b1);
            tick();
        end
        drv_load(b, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q[$];
        logic [31:0] ei;
        logic        ev;
        logic        fe, fz;
        logic [31:0] pc;
        bit          merge;

        rst = 1'b1;
        drv_load(0, 0, 0, 32'h0, 0); drv_fetch(0, 0, 0, 32'h0);
        drv_load(1, 0, 0, 32'h0, 0); drv_fetch(1, 0, 0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check_outs(0, "rst_a", 32'h0, 1'b0, 1'b0);
        check("rst_a.ovf", 32'(bus_a.load_overflow), 32'h0);
        check_outs(1, "rst_b", 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();

        // load_done while EMPTY must not enter RUN
        drv_load(0, 0, 0, 32'h0, 1);
        tick();
        drv_load(0, 0, 0, 32'h0, 0);
        tick(); tick();
        check("done_ignored", 32'(bus_a.ready), 32'h0);

        // basic 4-word program
        prog_a = '{32'hE3A00015, 32'hE3A01A01, 32'hE3A0DC02, 32'hE58F0000};
        load_prog(0, prog_a, 1'b0);
        check("ready_lag", 32'(bus_a.ready), 32'h0);
        tick();
        check("ready_up", 32'(bus_a.ready), 32'h1);
        check("ovf_none", 32'(bus_a.load_overflow), 32'h0);
        for (int i = 0; i < 4; i++) begin
            drv_fetch(0, 1, 0, 32'(i * 4));
            tick();
            check_outs(0, "fetch4", ref_fetch(0, 32'(i * 4)), 1'b1, 1'b1);
        end
        drv_fetch(0, 1, 0, 32'h10);
        tick();
        check_outs(0, "past_end", 32'h0, 1'b1, 1'b1);
        drv_fetch(0, 1, 0, 32'h0001_0000);
        tick();
        check_outs(0, "upper_bits", 32'h0, 1'b1, 1'b1);

        // freeze holds the previous fetch
        drv_fetch(0, 1, 0, 32'h0);
        tick();
        check_outs(0, "pre_freeze", 32'hE3A00015, 1'b1, 1'b1);
        drv_fetch(0, 1, 1, 32'h4);
        repeat (3) begin
            tick();
            check_outs(0, "frozen", 32'hE3A00015, 1'b1, 1'b1);
        end
        drv_fetch(0, 1, 0, 32'h4);
        tick();
        check_outs(0, "unfrozen", 32'hE3A01A01, 1'b1, 1'b1);
        drv_fetch(0, 0, 0, 32'h8);
        tick();
        check_outs(0, "idle_hold", 32'hE3A01A01, 1'b0, 1'b1);

        // reset in the middle of a load
        drv_load(0, 1, 0, 32'h0, 0);
        tick();
        drv_load(0, 0, 1, 32'h1111_1111, 0);
        tick();
        drv_load(0, 0, 1, 32'h2222_2222, 0);
        tick();
        drv_load(0, 0, 0, 32'h0, 0);
        rst = 1'b1;
        #1;
        check_outs(0, "rst_async", 32'h0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        prog_a = {};
        drv_fetch(0, 1, 0, 32'h0);
        repeat (3) begin
            tick();
            check_outs(0, "post_rst", 32'h0, 1'b0, 1'b0);
        end

        // final word and load_done in the same cycle
        drv_fetch(0, 0, 0, 32'h0);
        prog_a = '{32'hC000_0001, 32'hC000_0002, 32'hC000_0003};
        load_prog(0, prog_a, 1'b1);
        tick();
        check("merge.ready", 32'(bus_a.ready), 32'h1);
        drv_fetch(0, 1, 0, 32'h8);
        tick();
        check_outs(0, "merge_w2", 32'hC000_0003, 1'b1, 1'b1);
        drv_fetch(0, 1, 0, 32'hC);
        tick();
        check_outs(0, "merge_w3", 32'h0, 1'b1, 1'b1);
        drv_fetch(0, 1, 0, 32'h4);
        tick();
        check_outs(0, "merge_w1", 32'hC000_0002, 1'b1, 1'b1);

        // load_start with load_valid while RUN and fetching: no write, outputs cleared
        drv_load(0, 1, 1, 32'hDEAD_BEEF, 0);
        tick();
        check_outs(0, "start_in_run", 32'h0, 1'b0, 1'b0);
        drv_fetch(0, 0, 0, 32'h0);
        drv_load(0, 0, 1, 32'hAAAA_0001, 1);
        tick();
        drv_load(0, 0, 0, 32'h0, 0);
        prog_a = '{32'hAAAA_0001};
        tick();
        check("restart.ready", 32'(bus_a.ready), 32'h1);
        drv_fetch(0, 1, 0, 32'h0);
        tick();
        check_outs(0, "ptr_zero", 32'hAAAA_0001, 1'b1, 1'b1);
        drv_fetch(0, 1, 0, 32'h4);
        tick();
        check_outs(0, "one_word", 32'h0, 1'b1, 1'b1);
        drv_fetch(0, 0, 0, 32'h0);

        // DEPTH=4 overflow
        drv_load(1, 1, 0, 32'h0, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drv_load(1, 0, 1, 32'hB000_0000 + 32'(i), 0);
            tick();
            if (i == 3) check("ovf_early", 32'(bus_b.load_overflow), 32'h0);
        end
        check("ovf_set", 32'(bus_b.load_overflow), 32'h1);
        drv_load(1, 0, 0, 32'h0, 1);
        tick();
        drv_load(1, 0, 0, 32'h0, 0);
        prog_b = '{32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003};
        tick();
        check("ovf_sticky", 32'(bus_b.load_overflow), 32'h1);
        check("b.ready", 32'(bus_b.ready), 32'h1);
        foreach (prog_b[i]) begin
            pc = 32'(i * 4);
            drv_fetch(1, 1, 0, pc);
            tick();
            check_outs(1, "b_fetch", ref_fetch(1, pc), 1'b1, 1'b1);
        end
        drv_fetch(1, 1, 0, 32'h10);
        tick();
        check_outs(1, "b_range", 32'h0, 1'b1, 1'b1);
        drv_fetch(1, 0, 0, 32'h0);
        drv_load(1, 1, 0, 32'h0, 0);
        tick();
        drv_load(1, 0, 0, 32'h0, 0);
        check("ovf_clear", 32'(bus_b.load_overflow), 32'h0);

        // randomized programs and fetch traffic against the model
        for (int it = 0; it < 10; it++) begin
            q = {};
            repeat ($urandom_range(1, 40)) q.push_back($urandom);
            merge = 1'($urandom % 2);
            drv_fetch(0, 0, 0, 32'h0);
            load_prog(0, q, merge);
            prog_a = q;
            tick();
            check("rnd.ready", 32'(bus_a.ready), 32'h1);
            ei = 32'h0;
            ev = 1'b0;
            for (int c = 0; c < 60; c++) begin
                fe = ($urandom % 4) != 0;
                fz = ($urandom % 5) == 0;
                if ($urandom % 6 == 0) pc = $urandom;
                else pc = (32'($urandom_range(0, 47)) << 2) | 32'($urandom % 4);
                drv_fetch(0, fe, fz, pc);
                tick();
                if (!fz) begin
                    if (fe) begin
                        ev = 1'b1;
                        ei = ref_fetch(0, pc);
                    end else begin
                        ev = 1'b0;
                    end
                end
                check_outs(0, "rnd", ei, ev, 1'b1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
